// File: rtl/debounce_pkg.sv
// Shared state encoding and timer sizing helper for the debounce controller.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        CHECK_HIGH  = 2'b01,
        STABLE_HIGH = 2'b11,
        CHECK_LOW   = 2'b10
    } dbnc_state_e;

    // Wide enough to hold STABLE_TICKS-1, never narrower than one bit.
    function automatic int timer_width(input int ticks);
        return (ticks <= 2) ? 1 : $clog2(ticks);
    endfunction

endpackage

// File: rtl/debounce_timer.sv
// Tick-enabled stability timer with synchronous clear; done is combinational
// and flags the tick that completes STABLE_TICKS qualifying ticks.
module debounce_timer
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = 1000,
    parameter int TW           = timer_width(STABLE_TICKS)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic tick,
    output logic done
);

    localparam logic [TW-1:0] LAST = TW'(STABLE_TICKS - 1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    assign done = tick && (count_q == LAST);

    // Holding at LAST on the completing tick keeps the count from ever wrapping.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (tick && !done) begin
            count_d = count_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/debounce_ctrl.sv
// Debounces a synchronized level: 1 clock to enter a check, then STABLE_TICKS ticks.
// Optional rise/fall one-cycle pulses exist only with DEBOUNCE_EDGE_EN defined.
module debounce_ctrl
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = 1000,
    parameter int GLITCH_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sync_in,
    input  logic                tick,
    output logic                debounced,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
`ifdef DEBOUNCE_EDGE_EN
    ,
    output logic                rise_pulse,
    output logic                fall_pulse
`endif
);

    dbnc_state_e         state_q, state_d;
    logic                timer_clr, timer_done;
    logic                accept_rise, accept_fall, abort;
    logic                debounced_q, debounced_d;
    logic                busy_q, busy_d;
    logic [GLITCH_W-1:0] glitch_q, glitch_d;

    debounce_timer #(.STABLE_TICKS(STABLE_TICKS)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timer_clr),
        .tick  (tick),
        .done  (timer_done)
    );

    // A reverted input is tested before the tick, so an abort never counts.
    always_comb begin
        state_d     = state_q;
        timer_clr   = 1'b1;
        accept_rise = 1'b0;
        accept_fall = 1'b0;
        abort       = 1'b0;
        case (state_q)
            STABLE_LOW: begin
                if (sync_in) state_d = CHECK_HIGH;
            end
            CHECK_HIGH: begin
                if (!sync_in) begin
                    state_d = STABLE_LOW;
                    abort   = 1'b1;
                end else if (timer_done) begin
                    state_d     = STABLE_HIGH;
                    accept_rise = 1'b1;
                end else begin
                    timer_clr = 1'b0;
                end
            end
            STABLE_HIGH: begin
                if (!sync_in) state_d = CHECK_LOW;
            end
            CHECK_LOW: begin
                if (sync_in) begin
                    state_d = STABLE_HIGH;
                    abort   = 1'b1;
                end else if (timer_done) begin
                    state_d     = STABLE_LOW;
                    accept_fall = 1'b1;
                end else begin
                    timer_clr = 1'b0;
                end
            end
            default: state_d = STABLE_LOW;
        endcase
    end

    always_comb begin
        busy_d      = (state_d == CHECK_HIGH) || (state_d == CHECK_LOW);
        debounced_d = debounced_q;
        if (accept_rise) debounced_d = 1'b1;
        if (accept_fall) debounced_d = 1'b0;
        glitch_d = glitch_q;
        if (abort && !(&glitch_q)) glitch_d = glitch_q + GLITCH_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= STABLE_LOW;
            debounced_q <= 1'b0;
            busy_q      <= 1'b0;
            glitch_q    <= '0;
        end else begin
            state_q     <= state_d;
            debounced_q <= debounced_d;
            busy_q      <= busy_d;
            glitch_q    <= glitch_d;
        end
    end

    assign debounced  = debounced_q;
    assign busy       = busy_q;
    assign glitch_cnt = glitch_q;

`ifdef DEBOUNCE_EDGE_EN
    logic rise_q, fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= accept_rise;
            fall_q <= accept_fall;
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
`endif

endmodule

// File: tb/tb_debounce_ctrl.sv
// Bench for debounce_ctrl: instance A (4 ticks, 2-bit glitch counter) and
// instances B/C (2 and 1 ticks) sharing a strobed tick.
module tb_debounce_ctrl;

`ifdef DEBOUNCE_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst_n, a_sync, a_tick, a_deb, a_busy, a_rise, a_fall;
    logic [1:0] a_gl;
    logic       b_rst_n, b_sync, b_tick, b_deb, b_busy, b_rise, b_fall;
    logic       c_deb, c_busy, c_rise, c_fall;
    logic [7:0] b_gl, c_gl;

    debounce_ctrl #(.STABLE_TICKS(4), .GLITCH_W(2)) u_a (
        .clk(clk), .rst_n(a_rst_n), .sync_in(a_sync), .tick(a_tick),
        .debounced(a_deb), .busy(a_busy), .glitch_cnt(a_gl)
`ifdef DEBOUNCE_EDGE_EN
        , .rise_pulse(a_rise), .fall_pulse(a_fall)
`endif
    );

    debounce_ctrl #(.STABLE_TICKS(2), .GLITCH_W(8)) u_b (
        .clk(clk), .rst_n(b_rst_n), .sync_in(b_sync), .tick(b_tick),
        .debounced(b_deb), .busy(b_busy), .glitch_cnt(b_gl)
`ifdef DEBOUNCE_EDGE_EN
        , .rise_pulse(b_rise), .fall_pulse(b_fall)
`endif
    );

    debounce_ctrl #(.STABLE_TICKS(1), .GLITCH_W(8)) u_c (
        .clk(clk), .rst_n(b_rst_n), .sync_in(b_sync), .tick(b_tick),
        .debounced(c_deb), .busy(c_busy), .glitch_cnt(c_gl)
`ifdef DEBOUNCE_EDGE_EN
        , .rise_pulse(c_rise), .fall_pulse(c_fall)
`endif
    );

`ifndef DEBOUNCE_EDGE_EN
    assign a_rise = 1'b0;
    assign a_fall = 1'b0;
    assign b_rise = 1'b0;
    assign b_fall = 1'b0;
    assign c_rise = 1'b0;
    assign c_fall = 1'b0;
`endif

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [7:0] pa(input logic d, input logic b, input logic [1:0] g,
                                      input logic r, input logic f);
        return {2'b00, d, b, g, r & EDGE, f & EDGE};
    endfunction

    function automatic logic [7:0] oa();
        return {2'b00, a_deb, a_busy, a_gl, a_rise, a_fall};
    endfunction

    function automatic logic [7:0] ob();
        return {b_deb, b_busy, c_deb, c_busy, b_rise, c_rise, b_gl[0], c_gl[0]};
    endfunction

    task automatic drive_a(input logic s, input logic t);
        @(negedge clk);
        a_sync = s;
        a_tick = t;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_b(input logic s, input logic t);
        @(negedge clk);
        b_sync = s;
        b_tick = t;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t x;
        logic [7:0] o;
        a_rst_n = 1'b0; a_sync = 1'b1; a_tick = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{"reset_a", pa(1'b0, 1'b0, 2'd0, 1'b0, 1'b0)});
        x = sb.pop_front(); o = oa(); n_checks++;
        if (o !== x.val) $display("FAIL %s: got %b want %b", x.name, o, x.val); else n_pass++;
        a_rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{$sformatf("rise_c%0d", i + 1),
                           pa(i >= 4, i < 4, 2'd0, i == 4, 1'b0)});
            drive_a(1'b1, 1'b1);
            x = sb.pop_front(); o = oa(); n_checks++;
            if (o !== x.val) $display("FAIL %s: got %b want %b", x.name, o, x.val); else n_pass++;
        end
    endtask

    task automatic test_fall_abort();
        exp_t x;
        logic [7:0] o;
        for (int i = 0; i < 11; i++) begin
            sb.push_back('{$sformatf("fall_abort_c%0d", i + 1),
                           pa(i < 9, (i != 4) && (i < 9), (i >= 4) ? 2'd1 : 2'd0, 1'b0, i == 9)});
            drive_a(i == 4, 1'b1);
            x = sb.pop_front(); o = oa(); n_checks++;
            if (o !== x.val) $display("FAIL %s: got %b want %b", x.name, o, x.val); else n_pass++;
        end
    endtask

    task automatic test_glitch();
        exp_t x;
        logic [7:0] o;
        a_rst_n = 1'b0; a_sync = 1'b0;
        #1;
        sb.push_back('{"glitch_reset", pa(1'b0, 1'b0, 2'd0, 1'b0, 1'b0)});
        x = sb.pop_front(); o = oa(); n_checks++;
        if (o !== x.val) $display("FAIL %s: got %b want %b", x.name, o, x.val); else n_pass++;
        a_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{$sformatf("glitch_c%0d", i + 1),
                           pa(1'b0, i < 3, (i >= 3) ? 2'd1 : 2'd0, 1'b0, 1'b0)});
            drive_a(i < 3, 1'b1);
            x = sb.pop_front(); o = oa(); n_checks++;
            if (o !== x.val) $display("FAIL %s: got %b want %b", x.name, o, x.val); else n_pass++;
        end
    endtask

    task automatic test_saturation();
        exp_t x;
        logic [7:0] o;
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{$sformatf("sat_enter%0d", k),
                           pa(1'b0, 1'b1, 2'((k + 1 > 3) ? 3 : k + 1), 1'b0, 1'b0)});
            drive_a(1'b1, 1'b1);
            x = sb.pop_front(); o = oa(); n_checks++;
            if (o !== x.val) $display("FAIL %s: got %b want %b", x.name, o, x.val); else n_pass++;
            sb.push_back('{$sformatf("sat_abort%0d", k),
                           pa(1'b0, 1'b0, 2'((k + 2 > 3) ? 3 : k + 2), 1'b0, 1'b0)});
            drive_a(1'b0, 1'b1);
            x = sb.pop_front(); o = oa(); n_checks++;
            if (o !== x.val) $display("FAIL %s: got %b want %b", x.name, o, x.val); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_check();
        exp_t x;
        logic [7:0] o;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{$sformatf("mid_pre_c%0d", i + 1), pa(1'b0, 1'b1, 2'd3, 1'b0, 1'b0)});
            drive_a(1'b1, 1'b1);
            x = sb.pop_front(); o = oa(); n_checks++;
            if (o !== x.val) $display("FAIL %s: got %b want %b", x.name, o, x.val); else n_pass++;
        end
        #2;
        a_rst_n = 1'b0;
        sb.push_back('{"mid_reset", pa(1'b0, 1'b0, 2'd0, 1'b0, 1'b0)});
        #1;
        x = sb.pop_front(); o = oa(); n_checks++;
        if (o !== x.val) $display("FAIL %s: got %b want %b", x.name, o, x.val); else n_pass++;
        a_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{$sformatf("mid_post_c%0d", i + 1),
                           pa(i == 4, i < 4, 2'd0, i == 4, 1'b0)});
            drive_a(1'b1, 1'b1);
            x = sb.pop_front(); o = oa(); n_checks++;
            if (o !== x.val) $display("FAIL %s: got %b want %b", x.name, o, x.val); else n_pass++;
        end
    endtask

    // Starts on the cycle right after the rising acceptance.
    task automatic test_back_to_back();
        exp_t x;
        logic [7:0] o;
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{$sformatf("b2b_c%0d", i + 1),
                           pa(i < 4, i < 4, 2'd0, 1'b0, i == 4)});
            drive_a(1'b0, 1'b1);
            x = sb.pop_front(); o = oa(); n_checks++;
            if (o !== x.val) $display("FAIL %s: got %b want %b", x.name, o, x.val); else n_pass++;
        end
    endtask

    task automatic test_strobed_tick();
        exp_t x;
        logic [7:0] o;
        b_sync = 1'b1; b_tick = 1'b0;
        #1;
        sb.push_back('{"strobe_reset", 8'h00});
        x = sb.pop_front(); o = ob(); n_checks++;
        if (o !== x.val) $display("FAIL %s: got %b want %b", x.name, o, x.val); else n_pass++;
        b_rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            sb.push_back('{$sformatf("strobe_c%0d", k),
                           {k >= 6, k < 6, k >= 3, k < 3, (k == 6) & EDGE, (k == 3) & EDGE, 2'b00}});
            drive_b(1'b1, (k % 3) == 0);
            x = sb.pop_front(); o = ob(); n_checks++;
            if (o !== x.val) $display("FAIL %s: got %b want %b", x.name, o, x.val); else n_pass++;
        end
    endtask

    initial begin
        a_rst_n = 1'b0; a_sync = 1'b0; a_tick = 1'b0;
        b_rst_n = 1'b0; b_sync = 1'b0; b_tick = 1'b0;
        test_reset();
        test_fall_abort();
        test_glitch();
        test_saturation();
        test_reset_mid_check();
        test_back_to_back();
        test_strobed_tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
